// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and fetch stage feeding decode/execute.
// Drives a word-aligned fetch address to instruction memory, captures the
// returned word into an output holding register and presents it with its PC
// over a valid/ready handshake. Supports redirect (flush), halt and a fetch
// counter.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> misaligned redirects are rejected, set sticky misalign_err
//                and halt the fetch FSM.
//   undefined -> redirect_target[1:0] is zeroed; misalign_err port absent.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   Instruction_addr     fetch address (the PC register)
//   Instruction_Data     instruction word for Instruction_addr (combinational)
//   redirect_valid/target  load a new PC, flushing the output register
//   halt_req             stop fetching after the current cycle
//   instr_valid/ready    output handshake
//   instr_out, instr_pc, instr_pc_plus4  held instruction and its address
//   fetch_count          fetches since reset (wraps)
//   halted               FSM is in HALTED
//   misalign_err         sticky misaligned-redirect flag (macro builds only)
module instr_fetch_unit #(
  parameter int unsigned            ADDR_SIZE   = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [ADDR_SIZE-1:0]   RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_SIZE-1:0]   Instruction_addr,
  input  logic [INSTR_WIDTH-1:0] Instruction_Data,
  input  logic                   redirect_valid,
  input  logic [ADDR_SIZE-1:0]   redirect_target,
  input  logic                   halt_req,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_SIZE-1:0]   instr_pc,
  output logic [ADDR_SIZE-1:0]   instr_pc_plus4,
  output logic [31:0]            fetch_count,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                   misalign_err,
`endif
  output logic                   halted
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {START, RUN, HALTED} state_t;

  state_t                 state, state_next;
  logic [ADDR_SIZE-1:0]   pc, pc_next;
  logic                   valid_next;
  logic [INSTR_WIDTH-1:0] out_next;
  logic [ADDR_SIZE-1:0]   ipc_next, p4_next;
  logic [CNT_W-1:0]       cnt_next;
  logic                   do_fetch, do_redirect;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                   err_next;
`endif

  assign Instruction_addr = pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= START;
    else     state <= state_next;
  end

  // Next-state and datapath next values; redirect overrides fetch/stall/halt
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    valid_next  = instr_valid;
    out_next    = instr_out;
    ipc_next    = instr_pc;
    p4_next     = instr_pc_plus4;
    cnt_next    = fetch_count;
    do_fetch    = 1'b0;
    do_redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    err_next    = misalign_err;
`endif

    case (state)
      START: state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          do_redirect = 1'b1;
        end else begin
          do_fetch = !instr_valid || instr_ready;
          if (halt_req) state_next = HALTED;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          do_redirect = 1'b1;
          state_next  = RUN;
        end else if (instr_valid && instr_ready) begin
          valid_next = 1'b0;
        end
      end
      default: state_next = START;
    endcase

    if (do_redirect) begin
      valid_next = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      // Misaligned target: flush but keep the PC and stop fetching
      if (redirect_target[1:0] != 2'b00) begin
        err_next   = 1'b1;
        state_next = HALTED;
      end else begin
        pc_next = redirect_target & ~ADDR_SIZE'(3);
      end
`else
      pc_next = redirect_target & ~ADDR_SIZE'(3);
`endif
    end

    if (do_fetch) begin
      out_next   = Instruction_Data;
      ipc_next   = pc;
      p4_next    = pc + ADDR_SIZE'(4);
      valid_next = 1'b1;
      pc_next    = pc + ADDR_SIZE'(4);
      cnt_next   = fetch_count + CNT_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr_out      <= '0;
      instr_pc       <= '0;
      instr_pc_plus4 <= ADDR_SIZE'(4);
      fetch_count    <= '0;
      halted         <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_err   <= 1'b0;
`endif
    end else begin
      pc             <= pc_next;
      instr_valid    <= valid_next;
      instr_out      <= out_next;
      instr_pc       <= ipc_next;
      instr_pc_plus4 <= p4_next;
      fetch_count    <= cnt_next;
      halted         <= (state_next == HALTED);
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_err   <= err_next;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: table-driven per-cycle vectors plus
// hand-written misalign and mid-stall reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instruction_addr;
  logic [31:0] Instruction_Data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [31:0] fetch_count;
  logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .Instruction_addr (Instruction_addr),
    .Instruction_Data (Instruction_Data),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .halt_req         (halt_req),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .instr_pc_plus4   (instr_pc_plus4),
    .fetch_count      (fetch_count),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_err     (misalign_err),
`endif
    .halted           (halted)
  );

  // Instruction memory model: two fixed words, a distinct pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0109_8820;
    if (a == 32'h4) return 32'hAC11_0004;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  always_comb Instruction_Data = mem_word(Instruction_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic        halt;
    logic [31:0] tgt;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_addr;
    logic [31:0] e_cnt;
    logic        e_halted;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rd, input logic h, input logic [31:0] t,
                     input logic ev, input logic [31:0] eipc, input logic [31:0] ea,
                     input logic [31:0] ec, input logic eh);
    vec_t v;
    v.ready = r; v.redir = rd; v.halt = h; v.tgt = t;
    v.e_valid = ev; v.e_ipc = eipc; v.e_addr = ea; v.e_cnt = ec; v.e_halted = eh;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rd, input logic h, input logic [31:0] t);
    instr_ready = r; redirect_valid = rd; halt_req = h; redirect_target = t;
  endtask

  // Check the full output set against an expected state
  task automatic chk_state(input string tag, input logic ev, input logic [31:0] eipc,
                           input logic [31:0] ea, input logic [31:0] ec, input logic eh);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(ev));
    chk({tag, ".addr"}, Instruction_addr, ea);
    chk({tag, ".count"}, fetch_count, ec);
    chk({tag, ".halted"}, 32'(halted), 32'(eh));
    if (ev) begin
      chk({tag, ".pc"}, instr_pc, eipc);
      chk({tag, ".pc4"}, instr_pc_plus4, eipc + 32'd4);
      chk({tag, ".instr"}, instr_out, mem_word(eipc));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".out"}, instr_out, 32'd0);
    chk({tag, ".pc"}, instr_pc, 32'd0);
    chk({tag, ".pc4"}, instr_pc_plus4, 32'd4);
    chk({tag, ".count"}, fetch_count, 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
    chk({tag, ".addr"}, Instruction_addr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, ".err"}, 32'(misalign_err), 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ready redir halt target | valid ipc addr count halted
    add(1,0,0,32'h0,          0,32'h0,        32'h0,        0,  0); // START
    add(1,0,0,32'h0,          1,32'h0,        32'h4,        1,  0); // first fetch
    add(1,0,0,32'h0,          1,32'h4,        32'h8,        2,  0);
    add(1,0,0,32'h0,          1,32'h8,        32'hC,        3,  0);
    add(0,0,0,32'h0,          1,32'h8,        32'hC,        3,  0); // stall x3
    add(0,0,0,32'h0,          1,32'h8,        32'hC,        3,  0);
    add(0,0,0,32'h0,          1,32'h8,        32'hC,        3,  0);
    add(1,0,0,32'h0,          1,32'hC,        32'h10,       4,  0); // resume
    add(1,0,1,32'h0,          1,32'h10,       32'h14,       5,  1); // halt + last fetch
    add(0,0,0,32'h0,          1,32'h10,       32'h14,       5,  1); // halted, held
    add(1,0,0,32'h0,          0,32'h0,        32'h14,       5,  1); // drains
    add(1,0,1,32'h0,          0,32'h0,        32'h14,       5,  1); // halt_req ignored
    add(1,0,1,32'h0,          0,32'h0,        32'h14,       5,  1);
    add(1,0,1,32'h0,          0,32'h0,        32'h14,       5,  1);
    add(1,1,0,32'h0,          0,32'h0,        32'h0,        5,  0); // redirect from HALTED
    add(1,0,0,32'h0,          1,32'h0,        32'h4,        6,  0);
    add(1,0,0,32'h0,          1,32'h4,        32'h8,        7,  0);
    add(0,1,0,32'h18,         0,32'h0,        32'h18,       7,  0); // redirect over stall
    add(1,0,0,32'h0,          1,32'h18,       32'h1C,       8,  0);
    add(1,1,0,32'hFFFF_FFFC,  0,32'h0,        32'hFFFF_FFFC,8,  0); // wrap
    add(1,0,0,32'h0,          1,32'hFFFF_FFFC,32'h0,        9,  0);
    add(1,0,0,32'h0,          1,32'h0,        32'h4,        10, 0);
    add(1,0,0,32'h0,          1,32'h4,        32'h8,        11, 0);

    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #12;
    chk_reset_vals("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ready, tbl[i].redir, tbl[i].halt, tbl[i].tgt);
      step();
      chk_state($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ipc, tbl[i].e_addr,
                tbl[i].e_cnt, tbl[i].e_halted);
    end

    // Misaligned redirect while PC = 8
    drive(1'b1, 1'b1, 1'b0, 32'h6);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    chk_state("mis0", 1'b0, 32'h0, 32'h8, 32'd11, 1'b1);
    chk("mis0.err", 32'(misalign_err), 32'd1);
`else
    chk_state("mis0", 1'b0, 32'h0, 32'h4, 32'd11, 1'b0);
`endif
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    chk_state("mis1", 1'b0, 32'h0, 32'h8, 32'd11, 1'b1);
    chk("mis1.err", 32'(misalign_err), 32'd1);
`else
    chk_state("mis1", 1'b1, 32'h4, 32'h8, 32'd12, 1'b0);
`endif
    drive(1'b1, 1'b1, 1'b0, 32'h20);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    chk_state("mis2", 1'b0, 32'h0, 32'h20, 32'd11, 1'b0);
    chk("mis2.err", 32'(misalign_err), 32'd1);
`else
    chk_state("mis2", 1'b0, 32'h0, 32'h20, 32'd12, 1'b0);
`endif

    // Fetch once, then stall and reset asynchronously mid-cycle
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("pre.valid", 32'(instr_valid), 32'd1);
    chk("pre.pc", instr_pc, 32'h20);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("stall.pc", instr_pc, 32'h20);
    chk("stall.addr", Instruction_addr, 32'h24);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk_reset_vals("rst_held");
    #3;
    rst = 1'b0;
    step();
    chk_state("restart", 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    step();
    chk_state("refetch", 1'b1, 32'h0, 32'h4, 32'd1, 1'b0);
    chk("refetch.word", instr_out, 32'h0109_8820);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
